argmax_classifier: RTL
======================

Name: argmax_classifier

Overview:
- Final inference stage, directly downstream of the dense (fully connected) layer.
- Accepts the OUTPUT_SIZE signed class scores as a serial valid/ready stream, one score per cycle.
- Tracks the best and runner-up scores and reports the predicted class index, its score, the winning margin and a low-confidence flag.
- Signals completion with a one-cycle done pulse.

Parameters:
- OUTPUT_SIZE, 10: number of class scores per inference; must be >= 2.
- ACC_WIDTH, 32: signed width of each class score.
- MARGIN_THRESH, 64: unsigned threshold; a margin strictly below it sets low_conf.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin a new inference (level-sampled, see Behaviour).
- score_in  in  ACC_WIDTH  signed class score; class index is implied by arrival order, 0 first.
- score_valid  in  1  score_in is valid this cycle.
- score_ready  out  1  block can accept a score this cycle.
- class_idx  out  $clog2(OUTPUT_SIZE)  predicted class.
- max_score  out  ACC_WIDTH  signed score of the predicted class.
- margin  out  ACC_WIDTH+1  unsigned difference best minus runner-up.
- low_conf  out  1  margin < MARGIN_THRESH.
- busy  out  1  high in SCAN and REPORT.
- done  out  1  one-cycle pulse when results update.

Behaviour:
- Reset is asynchronous, active-high, and applies from any state:
  - state goes to IDLE.
  - All outputs go to 0: score_ready, busy, done, class_idx, max_score, margin, low_conf.
  - Internal count goes to 0.
  - Internal best and second registers are cleared.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - score_ready=0, busy=0.
  - start=1 at a rising edge moves to SCAN and initialises:
    - count=0, best_idx=0.
    - best = second = most-negative ACC_WIDTH value (1 followed by zeros).
- SCAN:
  - score_ready=1 (registered; asserted from the first SCAN cycle), busy=1.
  - A score is accepted on any edge where score_valid && score_ready.
  - Signed compare on each accepted score s:
    - If s > best: second <= best, best <= s, best_idx <= count.
    - Else if s > second: second <= s.
    - Otherwise no change.
  - Ties use strict greater-than, so the lowest index wins.
  - An equal score later in the stream updates second (when it exceeds second), so a tie yields margin 0.
  - count increments on each accept.
  - The accept with count == OUTPUT_SIZE-1 moves to REPORT; score_ready drops in that same edge.
  - score_valid low stalls SCAN indefinitely with no state change.
  - start=1 in SCAN aborts and re-initialises exactly as from IDLE (stays in SCAN). A score presented in the same cycle is discarded.
- REPORT (exactly one cycle):
  - score_ready=0, busy=1; start is ignored.
  - On the exiting edge, register:
    - class_idx = best_idx, max_score = best.
    - margin = best - second, computed in ACC_WIDTH+1 bits, always >= 0, no saturation.
    - low_conf = (margin < MARGIN_THRESH).
    - done=1 for one cycle.
  - Then go to IDLE.
- Latency: the last score is accepted on edge k; outputs and done are visible after edge k+1.
  - Minimum total is OUTPUT_SIZE+2 cycles from the start edge to done.
- Result outputs hold their values until the next REPORT or reset. An aborted scan does not alter them.
- Extreme values: score_in equal to the most-negative value never beats the initial best at index 0 unless it arrives first.
  - Index 0 is always the initial winner candidate: best_idx=0 stays if all scores equal the most-negative value, with margin=0.
- score_valid while in IDLE or REPORT is ignored; score_ready is low there.

Test Plan:
- Reset mid-SCAN after 4 scores accepted -> all outputs 0, state IDLE; a subsequent full run produces correct results unaffected by the partial data.
- start, then scores [5,-3,100,7,2,0,-50,99,1,4] back-to-back -> done exactly 12 cycles after the start edge, class_idx=2, max_score=100, margin=1, low_conf=1.
- Scores [-1000,-20,-900,-20,-5000,-7,-300,-400,-500,-600] with score_valid toggling 1/0 -> class_idx=5, max_score=-7, margin=13, low_conf=1; score_ready never drops during gaps.
- Tie: scores all 0 except idx3=500 and idx8=500 -> class_idx=3, margin=0; all scores equal 42 -> class_idx=0, margin=0.
- Wide range: idx0=+2^31-1, rest -2^31 -> class_idx=0, margin=2^32-1 (33-bit, no overflow), low_conf=0.
- Abort: start again after 6 scores, then a full 10-score run with max 300 at idx9 and runner-up 100 -> class_idx=9, margin=200, low_conf=0; exactly one done pulse; prior results held until that pulse.

Source files
------------

// File: rtl/argmax_classifier.sv
// Streaming argmax over a fixed-length run of signed class scores.
// Tracks best/runner-up while scanning and publishes index, score, margin and a low-confidence flag.
module argmax_classifier #(
    parameter int OUTPUT_SIZE   = 10,
    parameter int ACC_WIDTH     = 32,
    parameter int MARGIN_THRESH = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic signed [ACC_WIDTH-1:0]          score_in,
    input  logic                                 score_valid,
    output logic                                 score_ready,
    output logic [$clog2(OUTPUT_SIZE)-1:0]       class_idx,
    output logic signed [ACC_WIDTH-1:0]          max_score,
    output logic [ACC_WIDTH:0]                   margin,
    output logic                                 low_conf,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IDX_W = $clog2(OUTPUT_SIZE);
    localparam logic signed [ACC_WIDTH-1:0] MOST_NEG = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
    localparam logic [ACC_WIDTH:0] THRESH = (ACC_WIDTH+1)'(MARGIN_THRESH);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            count_q, count_d;
    logic [IDX_W-1:0]            best_idx_q, best_idx_d;
    logic signed [ACC_WIDTH-1:0] best_q, best_d;
    logic signed [ACC_WIDTH-1:0] second_q, second_d;
    logic                        score_ready_q, score_ready_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [IDX_W-1:0]            class_idx_q, class_idx_d;
    logic signed [ACC_WIDTH-1:0] max_score_q, max_score_d;
    logic [ACC_WIDTH:0]          margin_q, margin_d;
    logic                        low_conf_q, low_conf_d;

    logic                        accept;
    logic [ACC_WIDTH:0]          diff;

    // best >= second always holds, so the sign-extended difference is never negative
    assign diff   = {best_q[ACC_WIDTH-1], best_q} - {second_q[ACC_WIDTH-1], second_q};
    assign accept = score_valid && score_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        best_idx_d  = best_idx_q;
        best_d      = best_q;
        second_d    = second_q;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        margin_d    = margin_q;
        low_conf_d  = low_conf_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    count_d    = '0;
                    best_idx_d = '0;
                    best_d     = MOST_NEG;
                    second_d   = MOST_NEG;
                end
            end
            SCAN: begin
                // A restart wins over a score presented in the same cycle
                if (start) begin
                    count_d    = '0;
                    best_idx_d = '0;
                    best_d     = MOST_NEG;
                    second_d   = MOST_NEG;
                end else if (accept) begin
                    if (score_in > best_q) begin
                        second_d   = best_q;
                        best_d     = score_in;
                        best_idx_d = count_q;
                    end else if (score_in > second_q) begin
                        second_d = score_in;
                    end
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                class_idx_d = best_idx_q;
                max_score_d = best_q;
                margin_d    = diff;
                low_conf_d  = (diff < THRESH);
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        score_ready_d = (state_d == SCAN);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            best_idx_q    <= '0;
            best_q        <= '0;
            second_q      <= '0;
            score_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            class_idx_q   <= '0;
            max_score_q   <= '0;
            margin_q      <= '0;
            low_conf_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            best_idx_q    <= best_idx_d;
            best_q        <= best_d;
            second_q      <= second_d;
            score_ready_q <= score_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            class_idx_q   <= class_idx_d;
            max_score_q   <= max_score_d;
            margin_q      <= margin_d;
            low_conf_q    <= low_conf_d;
        end
    end

    assign score_ready = score_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
    assign margin      = margin_q;
    assign low_conf    = low_conf_q;

endmodule
